// File: rtl/vga_ctrl_pkg.sv
// Shared op codes, mode encodings and widths for the VGA scroll sequencer.
package vga_ctrl_pkg;

    localparam int unsigned OFS_W      = 10;
    localparam int unsigned SPD_W_DEF  = 6;
    localparam int unsigned X_WRAP_DEF = 1024;
    localparam int unsigned Y_WRAP_DEF = 480;
    localparam int unsigned FC_W       = 8;
    localparam int unsigned PAT_W      = 2;

    typedef enum logic [1:0] {
        OP_SET_SPD_X    = 2'd0,
        OP_SET_SPD_Y    = 2'd1,
        OP_SET_MODE     = 2'd2,
        OP_SET_PAT_ZERO = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_PAUSE = 2'd1,
        MODE_STEP  = 2'd2
    } mode_e;

endpackage

// File: rtl/vga_scroll_sequencer_if.sv
// Command port of the scroll sequencer: valid/ready handshake with op and argument.
interface vga_scroll_sequencer_if #(
    parameter int unsigned SPD_W = 6
) ();
    import vga_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    cmd_op_e          cmd_op;
    logic [SPD_W-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);

endinterface

// File: rtl/scroll_wrap_add.sv
// Combinational offset + signed speed, wrapped into 0..WRAP-1 (|speed| < WRAP assumed).
module scroll_wrap_add
    import vga_ctrl_pkg::*;
#(
    parameter int unsigned WRAP  = 480,
    parameter int unsigned SPD_W = SPD_W_DEF
) (
    input  logic [OFS_W-1:0] ofs_i,
    input  logic [SPD_W-1:0] spd_i,
    output logic [OFS_W-1:0] ofs_o
);

    localparam int unsigned SUM_W     = OFS_W + 1;
    localparam bit          WRAP_POW2 = ((WRAP & (WRAP - 1)) == 0);

    generate
        if (WRAP_POW2) begin : g_pow2
            // Power-of-two modulus: two's complement add, then drop the high bits.
            logic [OFS_W-1:0] spd_ext;
            logic [OFS_W-1:0] sum;
            assign spd_ext = {{(OFS_W - SPD_W){spd_i[SPD_W-1]}}, spd_i};
            assign sum     = ofs_i + spd_ext;
            assign ofs_o   = sum & OFS_W'(WRAP - 1);
        end else begin : g_mod
            logic signed [SUM_W-1:0] sum_s;
            logic signed [SUM_W-1:0] wrap_s;
            assign wrap_s = SUM_W'(WRAP);
            assign sum_s  = $signed({1'b0, ofs_i})
                          + $signed({{(SUM_W - SPD_W){spd_i[SPD_W-1]}}, spd_i});
            // A single correction in either direction suffices.
            always_comb begin
                if (sum_s[SUM_W-1]) begin
                    ofs_o = OFS_W'(sum_s + wrap_s);
                end else if (sum_s >= wrap_s) begin
                    ofs_o = OFS_W'(sum_s - wrap_s);
                end else begin
                    ofs_o = OFS_W'(sum_s);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/vga_scroll_sequencer.sv
// Frame-synchronous scroll/pattern controller: commands land in registers at once,
// display-visible offsets and pattern change only on frame_start.
module vga_scroll_sequencer
    import vga_ctrl_pkg::*;
#(
    parameter int unsigned X_WRAP = X_WRAP_DEF,
    parameter int unsigned Y_WRAP = Y_WRAP_DEF,
    parameter int unsigned SPD_W  = SPD_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    vga_scroll_sequencer_if.slave cmd,
    output logic [OFS_W-1:0]     scroll_x,
    output logic [OFS_W-1:0]     scroll_y,
    output logic [PAT_W-1:0]     pattern_sel,
    output logic [FC_W-1:0]      frame_count,
    output logic [1:0]           mode
);

    mode_e              state_q, state_d;
    logic [SPD_W-1:0]   spd_x_q, spd_x_d;
    logic [SPD_W-1:0]   spd_y_q, spd_y_d;
    logic [PAT_W-1:0]   pend_pat_q, pend_pat_d;
    logic               pend_zero_q, pend_zero_d;
    logic [OFS_W-1:0]   scroll_x_q, scroll_x_d;
    logic [OFS_W-1:0]   scroll_y_q, scroll_y_d;
    logic [PAT_W-1:0]   pattern_sel_q, pattern_sel_d;
    logic [FC_W-1:0]    frame_count_q, frame_count_d;

    logic [OFS_W-1:0]   x_next;
    logic [OFS_W-1:0]   y_next;
    logic               cmd_accept;
    logic               advance;

    scroll_wrap_add #(.WRAP(X_WRAP), .SPD_W(SPD_W)) u_wrap_x (
        .ofs_i (scroll_x_q),
        .spd_i (spd_x_q),
        .ofs_o (x_next)
    );

    scroll_wrap_add #(.WRAP(Y_WRAP), .SPD_W(SPD_W)) u_wrap_y (
        .ofs_i (scroll_y_q),
        .spd_i (spd_y_q),
        .ofs_o (y_next)
    );

    // Commands are refused only in the frame-update cycle, so the two never collide.
    assign cmd.cmd_ready = ~frame_start;
    assign cmd_accept    = cmd.cmd_valid & ~frame_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MODE_RUN;
            spd_x_q       <= '0;
            spd_y_q       <= '0;
            pend_pat_q    <= '0;
            pend_zero_q   <= 1'b0;
            scroll_x_q    <= '0;
            scroll_y_q    <= '0;
            pattern_sel_q <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            spd_x_q       <= spd_x_d;
            spd_y_q       <= spd_y_d;
            pend_pat_q    <= pend_pat_d;
            pend_zero_q   <= pend_zero_d;
            scroll_x_q    <= scroll_x_d;
            scroll_y_q    <= scroll_y_d;
            pattern_sel_q <= pattern_sel_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        spd_x_d       = spd_x_q;
        spd_y_d       = spd_y_q;
        pend_pat_d    = pend_pat_q;
        pend_zero_d   = pend_zero_q;
        scroll_x_d    = scroll_x_q;
        scroll_y_d    = scroll_y_q;
        pattern_sel_d = pattern_sel_q;
        frame_count_d = frame_count_q;
        advance       = 1'b0;

        if (frame_start) begin
            frame_count_d = frame_count_q + FC_W'(1);
            pattern_sel_d = pend_pat_q;
            case (state_q)
                MODE_RUN:  advance = 1'b1;
                MODE_STEP: begin
                    advance = 1'b1;
                    state_d = MODE_PAUSE;
                end
                default:   advance = 1'b0;
            endcase
            // A pending zero wins over the advance but not over the STEP->PAUSE move.
            if (pend_zero_q) begin
                scroll_x_d  = '0;
                scroll_y_d  = '0;
                pend_zero_d = 1'b0;
            end else if (advance) begin
                scroll_x_d = x_next;
                scroll_y_d = y_next;
            end
        end else if (cmd_accept) begin
            case (cmd.cmd_op)
                OP_SET_SPD_X: spd_x_d = cmd.cmd_arg;
                OP_SET_SPD_Y: spd_y_d = cmd.cmd_arg;
                OP_SET_MODE: begin
                    if (cmd.cmd_arg[1:0] != 2'd3) begin
                        state_d = mode_e'(cmd.cmd_arg[1:0]);
                    end
                end
                OP_SET_PAT_ZERO: begin
                    pend_pat_d  = cmd.cmd_arg[1:0];
                    pend_zero_d = cmd.cmd_arg[2];
                end
                default: ;
            endcase
        end
    end

    assign scroll_x    = scroll_x_q;
    assign scroll_y    = scroll_y_q;
    assign pattern_sel = pattern_sel_q;
    assign frame_count = frame_count_q;
    assign mode        = state_q;

endmodule

// File: tb/tb_vga_scroll_sequencer.sv
// Bench for vga_scroll_sequencer: directed table, wrap/handshake/reset sequences, random vs model.
module tb_vga_scroll_sequencer;
    import vga_ctrl_pkg::*;

    localparam int XW = 1024;
    localparam int YW = 480;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] scroll_x, scroll_y;
    logic [1:0] pattern_sel;
    logic [7:0] frame_count;
    logic [1:0] mode;

    vga_scroll_sequencer_if #(.SPD_W(6)) cif ();

    vga_scroll_sequencer #(.X_WRAP(XW), .Y_WRAP(YW), .SPD_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .cmd         (cif),
        .scroll_x    (scroll_x),
        .scroll_y    (scroll_y),
        .pattern_sel (pattern_sel),
        .frame_count (frame_count),
        .mode        (mode)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, plain integers
    int m_x, m_y, m_spx, m_spy, m_pat, m_ppat, m_pz, m_fc, m_mode;

    typedef struct {
        logic       fs;
        logic       v;
        logic [1:0] op;
        logic [5:0] arg;
        int         ex, ey, efc, emode, epat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic fs, logic v, logic [1:0] op, logic [5:0] arg,
                                int ex, int ey, int efc, int emode, int epat);
        vec_t r;
        r.fs = fs; r.v = v; r.op = op; r.arg = arg;
        r.ex = ex; r.ey = ey; r.efc = efc; r.emode = emode; r.epat = epat;
        return r;
    endfunction

    function automatic int wrapmod(int v, int m);
        int r;
        r = v % m;
        if (r < 0) r += m;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_update(logic rst, logic fs, logic v, logic [1:0] op, logic [5:0] arg);
        if (rst) begin
            m_x = 0; m_y = 0; m_spx = 0; m_spy = 0; m_pat = 0;
            m_ppat = 0; m_pz = 0; m_fc = 0; m_mode = 0;
        end else if (fs) begin
            m_fc  = (m_fc + 1) % 256;
            m_pat = m_ppat;
            if (m_pz != 0) begin
                m_x = 0; m_y = 0; m_pz = 0;
            end else if (m_mode != 1) begin
                m_x = wrapmod(m_x + m_spx, XW);
                m_y = wrapmod(m_y + m_spy, YW);
            end
            if (m_mode == 2) m_mode = 1;
        end else if (v) begin
            case (op)
                2'd0: m_spx = int'($signed(arg));
                2'd1: m_spy = int'($signed(arg));
                2'd2: if (arg[1:0] != 2'd3) m_mode = int'(arg[1:0]);
                default: begin
                    m_ppat = int'(arg[1:0]);
                    m_pz   = int'(arg[2]);
                end
            endcase
        end
    endtask

    // Drive one cycle of inputs, check cmd_ready, advance model, pass the edge.
    task automatic step(logic rst, logic fs, logic v, logic [1:0] op, logic [5:0] arg);
        reset         = rst;
        frame_start   = fs;
        cif.cmd_valid = v;
        cif.cmd_op    = cmd_op_e'(op);
        cif.cmd_arg   = arg;
        #1;
        chk("cmd_ready", int'(cif.cmd_ready), fs ? 0 : 1);
        model_update(rst, fs, v, op, arg);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        frame_start   = 1'b0;
        cif.cmd_valid = 1'b0;
    endtask

    task automatic chk_model(string tag);
        chk({tag, "_x"},    int'(scroll_x),    m_x);
        chk({tag, "_y"},    int'(scroll_y),    m_y);
        chk({tag, "_fc"},   int'(frame_count), m_fc);
        chk({tag, "_mode"}, int'(mode),        m_mode);
        chk({tag, "_pat"},  int'(pattern_sel), m_pat);
    endtask

    task automatic chk_const(string tag, int ex, int ey, int efc, int emode, int epat);
        chk({tag, "_x"},    int'(scroll_x),    ex);
        chk({tag, "_y"},    int'(scroll_y),    ey);
        chk({tag, "_fc"},   int'(frame_count), efc);
        chk({tag, "_mode"}, int'(mode),        emode);
        chk({tag, "_pat"},  int'(pattern_sel), epat);
    endtask

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = OP_SET_SPD_X;
        cif.cmd_arg   = '0;

        // Directed table starting from reset
        tbl.push_back(mk(0, 1, 2'd0, 6'd3,    0,    0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 2'd0, 6'd0,    3,    0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2'd0, 6'd0,    6,    0, 2, 0, 0));
        tbl.push_back(mk(1, 0, 2'd0, 6'd0,    9,    0, 3, 0, 0));
        tbl.push_back(mk(1, 0, 2'd0, 6'd0,   12,    0, 4, 0, 0));
        tbl.push_back(mk(0, 1, 2'd0, 6'h20,  12,    0, 4, 0, 0));
        tbl.push_back(mk(1, 0, 2'd0, 6'd0, 1004,    0, 5, 0, 0));
        tbl.push_back(mk(0, 1, 2'd3, 6'h05,1004,    0, 5, 0, 0));
        tbl.push_back(mk(1, 0, 2'd0, 6'd0,    0,    0, 6, 0, 1));
        tbl.push_back(mk(0, 1, 2'd2, 6'd1,    0,    0, 6, 1, 1));
        tbl.push_back(mk(1, 0, 2'd0, 6'd0,    0,    0, 7, 1, 1));
        tbl.push_back(mk(0, 1, 2'd2, 6'd2,    0,    0, 7, 2, 1));
        tbl.push_back(mk(1, 0, 2'd0, 6'd0,  992,    0, 8, 1, 1));
        tbl.push_back(mk(1, 0, 2'd0, 6'd0,  992,    0, 9, 1, 1));
        tbl.push_back(mk(0, 1, 2'd2, 6'd3,  992,    0, 9, 1, 1));
        tbl.push_back(mk(0, 1, 2'd1, 6'h3F, 992,    0, 9, 1, 1));
        tbl.push_back(mk(0, 1, 2'd2, 6'd0,  992,    0, 9, 0, 1));
        tbl.push_back(mk(1, 0, 2'd0, 6'd0,  960,  479,10, 0, 1));

        @(posedge clk);
        #1;
        step(1, 0, 0, 2'd0, 6'd0);
        chk_const("reset", 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(0, tbl[i].fs, tbl[i].v, tbl[i].op, tbl[i].arg);
            chk_const($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].efc,
                      tbl[i].emode, tbl[i].epat);
        end

        // Y wrap in both directions
        step(1, 0, 0, 2'd0, 6'd0);
        step(0, 1, 1, 2'd1, 6'h3E);
        step(0, 0, 1, 2'd1, 6'h3E);
        step(0, 1, 0, 2'd0, 6'd0);
        chk("ywrap_478", int'(scroll_y), 478);
        step(0, 0, 1, 2'd1, 6'd5);
        step(0, 1, 0, 2'd0, 6'd0);
        chk("ywrap_up", int'(scroll_y), 3);
        step(0, 0, 1, 2'd1, 6'h3B);
        step(0, 1, 0, 2'd0, 6'd0);
        chk("ywrap_down", int'(scroll_y), 478);

        // X wrap past 1023
        step(1, 0, 0, 2'd0, 6'd0);
        step(0, 0, 1, 2'd0, 6'h3E);
        step(0, 1, 0, 2'd0, 6'd0);
        chk("xwrap_1022", int'(scroll_x), 1022);
        step(0, 0, 1, 2'd0, 6'd4);
        step(0, 1, 0, 2'd0, 6'd0);
        chk("xwrap_up", int'(scroll_x), 2);

        // Command held during frame_start is refused, then taken the next cycle
        step(0, 1, 1, 2'd0, 6'd7);
        chk("collide_old_spd", int'(scroll_x), 6);
        step(0, 0, 1, 2'd0, 6'd7);
        chk("collide_not_yet", int'(scroll_x), 6);
        step(0, 1, 0, 2'd0, 6'd0);
        chk("collide_applied", int'(scroll_x), 13);

        // Reset coinciding with frame_start clears everything
        step(0, 0, 1, 2'd3, 6'd2);
        step(0, 1, 0, 2'd0, 6'd0);
        chk("pre_rst_pat", int'(pattern_sel), 2);
        step(0, 0, 1, 2'd2, 6'd1);
        step(1, 1, 1, 2'd0, 6'd9);
        chk_const("rst_fs", 0, 0, 0, 0, 0);
        step(0, 1, 0, 2'd0, 6'd0);
        chk_const("rst_after", 0, 0, 1, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic       r_rst, r_fs, r_v;
            logic [1:0] r_op;
            logic [5:0] r_arg;
            r_rst = ($urandom_range(0, 99) == 0);
            r_fs  = ($urandom_range(0, 5) == 0);
            r_v   = ($urandom_range(0, 1) == 1);
            r_op  = 2'($urandom_range(0, 3));
            r_arg = 6'($urandom);
            step(r_rst, r_fs, r_v, r_op, r_arg);
            chk_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
